// File: rtl/aq_f_spsram_clr.sv
// Single-port SRAM model with per-bit write mask, read-data hold, arbitrary depth
// and a hardware clear sweep. Optional output register: AQ_F_SPSRAM_CLR_OREG_EN.
//
// state | meaning
// SWEEP | writing INIT_VALUE to entry cnt; accesses ignored, BUSY=1
// READY | normal CEN/GWEN/WEN accesses; CLR restarts the sweep
module aq_f_spsram_clr #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 58,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  CLR,
  output logic                  BUSY,
  output logic [DATA_WIDTH-1:0] Q
);

  localparam logic [0:0] SWEEP = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  // Terminal count fits in ADDR_WIDTH even when DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] q_hold;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic addr_ok;
  logic acc_rd;
  logic acc_wr;

  assign addr_ok = ({1'b0, A} < DEPTH_EXT);
  assign acc_rd  = (state == READY) && !CEN && GWEN;
  assign acc_wr  = (state == READY) && !CEN && !GWEN && addr_ok;

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state  <= SWEEP;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      case (state)
        SWEEP: begin
          if (cnt == CNT_LAST) begin
            state  <= READY;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          if (CLR) begin
            state  <= SWEEP;
            busy_q <= 1'b1;
            cnt    <= '0;
          end
        end
        default: begin
          state  <= SWEEP;
          busy_q <= 1'b1;
          cnt    <= '0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; the sweep defines its contents.
  always_ff @(posedge CLK) begin
    if (state == SWEEP) begin
      mem[cnt] <= INIT_VALUE;
    end else if (acc_wr) begin
      mem[A] <= (mem[A] & WEN) | (D & ~WEN);
    end
  end

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      q_hold <= '0;
    end else if (acc_rd) begin
      q_hold <= addr_ok ? mem[A] : '0;
    end
  end

  assign BUSY = busy_q;

`ifdef AQ_F_SPSRAM_CLR_OREG_EN
  logic [DATA_WIDTH-1:0] q_oreg;

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      q_oreg <= '0;
    end else begin
      q_oreg <= q_hold;
    end
  end

  assign Q = q_oreg;
`else
  assign Q = q_hold;
`endif

endmodule

// File: tb/tb_aq_f_spsram_clr.sv
// Bench for aq_f_spsram_clr: a full-depth (64) and a partial-depth (48) instance
// share stimulus and are checked against an entry-array model.
module tb_aq_f_spsram_clr;
  localparam int AW = 6;
  localparam int DW = 58;
  localparam logic [DW-1:0] INIT_A = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] INIT_B = 58'h2A5_5A5A_0F0F_1234;
  localparam logic [DW-1:0] ONES   = {DW{1'b1}};
`ifdef AQ_F_SPSRAM_CLR_OREG_EN
  localparam bit OREG = 1'b1;
`else
  localparam bit OREG = 1'b0;
`endif

  logic          clk;
  logic          rst_b;
  logic [AW-1:0] a_i;
  logic          cen_i, gwen_i, clr_i;
  logic [DW-1:0] wen_i, d_i;
  logic          busy_a, busy_b;
  logic [DW-1:0] q_a, q_b;
  logic          busy_w [2];
  logic [DW-1:0] q_w [2];

  int checks = 0;
  int failures = 0;

  // reference model state
  int            dep [2] = '{64, 48};
  logic [DW-1:0] init_v [2] = '{INIT_A, INIT_B};
  logic [DW-1:0] mm [2][64];
  logic          m_busy [2];
  int            m_left [2];
  logic [DW-1:0] m_qh [2];
  logic [DW-1:0] m_qo [2];
  logic [DW-1:0] m_q [2];

  aq_f_spsram_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64), .INIT_VALUE(INIT_A)) u_dut_a (
    .CLK(clk), .cpurst_b(rst_b), .A(a_i), .CEN(cen_i), .GWEN(gwen_i),
    .WEN(wen_i), .D(d_i), .CLR(clr_i), .BUSY(busy_a), .Q(q_a));

  aq_f_spsram_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(48), .INIT_VALUE(INIT_B)) u_dut_b (
    .CLK(clk), .cpurst_b(rst_b), .A(a_i), .CEN(cen_i), .GWEN(gwen_i),
    .WEN(wen_i), .D(d_i), .CLR(clr_i), .BUSY(busy_b), .Q(q_b));

  assign busy_w[0] = busy_a;
  assign busy_w[1] = busy_b;
  assign q_w[0]    = q_a;
  assign q_w[1]    = q_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b1;
      m_left[k] = dep[k];
      m_qh[k]   = '0;
      m_qo[k]   = '0;
      m_q[k]    = '0;
    end
  endtask

  // One clock edge; the model consumes the inputs that were present at the edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_b) begin
        m_busy[k] = 1'b1; m_left[k] = dep[k]; m_qh[k] = '0; m_qo[k] = '0;
      end else begin
        m_qo[k] = m_qh[k];
        if (m_busy[k]) begin
          mm[k][dep[k] - m_left[k]] = init_v[k];
          m_left[k]--;
          if (m_left[k] == 0) m_busy[k] = 1'b0;
        end else begin
          if (!cen_i) begin
            if (!gwen_i) begin
              if (int'(a_i) < dep[k]) mm[k][a_i] = (mm[k][a_i] & wen_i) | (d_i & ~wen_i);
            end else begin
              m_qh[k] = (int'(a_i) < dep[k]) ? mm[k][a_i] : '0;
            end
          end
          if (clr_i) begin
            m_busy[k] = 1'b1;
            m_left[k] = dep[k];
          end
        end
      end
      m_q[k] = OREG ? m_qo[k] : m_qh[k];
    end
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic cen, input logic gwen,
                       input logic [DW-1:0] wen, input logic [DW-1:0] d, input logic clr);
    a_i = a; cen_i = cen; gwen_i = gwen; wen_i = wen; d_i = d; clr_i = clr;
  endtask

  task automatic idle();
    drive('0, 1'b1, 1'b1, ONES, '0, 1'b0);
  endtask

  // issue a read and wait out the read latency
  task automatic do_read(input logic [AW-1:0] a);
    drive(a, 1'b0, 1'b1, ONES, '0, 1'b0);
    tick();
    idle();
    if (OREG) tick();
  endtask

  task automatic test_reset();
    int len [2];
    len = '{0, 0};
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (busy_w[k] !== 1'b1) begin failures++; $display("FAIL reset_busy dut%0d got=%0b exp=1", k, busy_w[k]); end
      checks++;
      if (q_w[k] !== '0) begin failures++; $display("FAIL reset_q dut%0d got=%h exp=0", k, q_w[k]); end
    end
    rst_b = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (busy_w[k] !== m_busy[k]) begin failures++; $display("FAIL sweep_busy dut%0d cyc=%0d got=%0b exp=%0b", k, cyc, busy_w[k], m_busy[k]); end
        if (len[k] == 0 && busy_w[k] === 1'b0) len[k] = cyc;
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (len[k] != dep[k]) begin failures++; $display("FAIL sweep_len dut%0d got=%0d exp=%0d", k, len[k], dep[k]); end
    end
    foreach (dep[i]) begin end
    for (int j = 0; j < 3; j++) begin
      logic [AW-1:0] ra;
      ra = (j == 0) ? 6'd0 : (j == 1) ? 6'd31 : 6'd63;
      do_read(ra);
      checks++;
      if (q_a !== INIT_A) begin failures++; $display("FAIL init_read_a addr=%0d got=%h exp=%h", ra, q_a, INIT_A); end
      checks++;
      if (q_b !== m_q[1]) begin failures++; $display("FAIL init_read_b addr=%0d got=%h exp=%h", ra, q_b, m_q[1]); end
    end
  endtask

  task automatic test_masked_write();
    logic [DW-1:0] exp_v;
    exp_v = ONES ^ 58'h1;
    drive(6'd5, 1'b0, 1'b0, '0, ONES, 1'b0); tick();
    drive(6'd5, 1'b0, 1'b0, ONES ^ 58'h1, '0, 1'b0); tick();
    drive(6'd5, 1'b0, 1'b1, ONES, '0, 1'b0); tick();
    idle();
    if (OREG) begin
      checks++;
      if (q_a === exp_v) begin failures++; $display("FAIL mask_latency got=%h exp=not %h", q_a, exp_v); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (q_w[k] !== exp_v) begin failures++; $display("FAIL mask_read dut%0d got=%h exp=%h", k, q_w[k], exp_v); end
    end
    // all-ones mask: no bit changes and Q holds
    drive(6'd5, 1'b0, 1'b0, ONES, '0, 1'b0); tick(); idle(); tick(); tick();
    checks++;
    if (q_a !== exp_v) begin failures++; $display("FAIL mask_none_hold got=%h exp=%h", q_a, exp_v); end
    do_read(6'd5);
    checks++;
    if (q_a !== exp_v) begin failures++; $display("FAIL mask_none_read got=%h exp=%h", q_a, exp_v); end
  endtask

  task automatic test_hold();
    logic [DW-1:0] exp_v;
    exp_v = ONES ^ 58'h1;
    do_read(6'd5);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) drive(6'd6, 1'b0, 1'b0, '0, 58'h155_5555_5555_5555, 1'b0);
      else drive(AW'($urandom), 1'b1, 1'($urandom), {$urandom, $urandom} >> 6, {$urandom, $urandom} >> 6, 1'b0);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (q_w[k] !== exp_v) begin failures++; $display("FAIL hold_q dut%0d cyc=%0d got=%h exp=%h", k, i, q_w[k], exp_v); end
      end
    end
    idle();
    do_read(6'd6);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (q_w[k] !== 58'h155_5555_5555_5555) begin failures++; $display("FAIL hold_wr6 dut%0d got=%h exp=%h", k, q_w[k], 58'h155_5555_5555_5555); end
    end
  endtask

  task automatic test_out_of_range();
    drive(6'd50, 1'b0, 1'b0, '0, 58'h1234, 1'b0); tick();
    drive(6'd47, 1'b0, 1'b0, '0, 58'h0BEE_F047, 1'b0); tick();
    do_read(6'd50);
    checks++;
    if (q_b !== '0) begin failures++; $display("FAIL oor_read_b got=%h exp=0", q_b); end
    checks++;
    if (q_a !== 58'h1234) begin failures++; $display("FAIL oor_read_a got=%h exp=1234", q_a); end
    do_read(6'd47);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (q_w[k] !== 58'h0BEE_F047) begin failures++; $display("FAIL last_entry dut%0d got=%h exp=%h", k, q_w[k], 58'h0BEE_F047); end
    end
  endtask

  task automatic test_clr();
    drive(6'd10, 1'b0, 1'b0, '0, 58'hABCD, 1'b0); tick();
    drive(6'd10, 1'b0, 1'b1, ONES, '0, 1'b1); tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (busy_w[k] !== 1'b1) begin failures++; $display("FAIL clr_busy_rise dut%0d got=%0b exp=1", k, busy_w[k]); end
    end
    if (OREG) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (q_w[k] !== 58'hABCD) begin failures++; $display("FAIL clr_preclear_q dut%0d got=%h exp=abcd", k, q_w[k]); end
    end
    // accesses during the sweep are ignored
    for (int i = 0; i < 70; i++) begin
      drive(6'd10, 1'b0, 1'(i % 2), '0, 58'h5555, 1'b0);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (busy_w[k] !== m_busy[k]) begin failures++; $display("FAIL clr_sweep_busy dut%0d cyc=%0d got=%0b exp=%0b", k, i, busy_w[k], m_busy[k]); end
        checks++;
        if (q_w[k] !== m_q[k]) begin failures++; $display("FAIL clr_sweep_q dut%0d cyc=%0d got=%h exp=%h", k, i, q_w[k], m_q[k]); end
      end
    end
    idle();
    tick();
    do_read(6'd10);
    checks++;
    if (q_a !== INIT_A && q_a !== m_q[0]) begin failures++; $display("FAIL clr_after_a got=%h exp=%h", q_a, m_q[0]); end
    checks++;
    if (q_b !== m_q[1]) begin failures++; $display("FAIL clr_after_b got=%h exp=%h", q_b, m_q[1]); end
    // dut_a was still sweeping when dut_b took the late writes, so re-clear both to isolate
    drive('0, 1'b1, 1'b1, ONES, '0, 1'b1); tick(); idle();
    for (int i = 0; i < 66; i++) tick();
    do_read(6'd10);
    checks++;
    if (q_a !== INIT_A) begin failures++; $display("FAIL clr_init_a got=%h exp=%h", q_a, INIT_A); end
    checks++;
    if (q_b !== INIT_B) begin failures++; $display("FAIL clr_init_b got=%h exp=%h", q_b, INIT_B); end
  endtask

  task automatic test_reset_mid_sweep();
    int len [2];
    len = '{0, 0};
    drive(6'd1, 1'b0, 1'b0, '0, 58'h77, 1'b0); tick();
    do_read(6'd1);
    drive('0, 1'b1, 1'b1, ONES, '0, 1'b1); tick(); idle();
    for (int i = 0; i < 20; i++) tick();
    rst_b = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (busy_w[k] !== 1'b1) begin failures++; $display("FAIL rst_mid_busy dut%0d got=%0b exp=1", k, busy_w[k]); end
        checks++;
        if (q_w[k] !== '0) begin failures++; $display("FAIL rst_mid_q dut%0d got=%h exp=0", k, q_w[k]); end
      end
      tick();
    end
    rst_b = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      tick();
      for (int k = 0; k < 2; k++)
        if (len[k] == 0 && busy_w[k] === 1'b0) len[k] = cyc;
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (len[k] != dep[k]) begin failures++; $display("FAIL rst_mid_len dut%0d got=%0d exp=%0d", k, len[k], dep[k]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(AW'($urandom_range(0, 63)), ($urandom_range(0, 3) == 0), 1'($urandom),
            ($urandom_range(0, 1) == 0) ? '0 : DW'({$urandom, $urandom}),
            DW'({$urandom, $urandom}), ($urandom_range(0, 79) == 0));
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (busy_w[k] !== m_busy[k]) begin failures++; $display("FAIL rand_busy dut%0d cyc=%0d got=%0b exp=%0b", k, i, busy_w[k], m_busy[k]); end
        checks++;
        if (q_w[k] !== m_q[k]) begin failures++; $display("FAIL rand_q dut%0d cyc=%0d got=%h exp=%h", k, i, q_w[k], m_q[k]); end
      end
    end
    idle();
  endtask

  initial begin
    rst_b = 1'b0;
    idle();
    model_reset();
    repeat (3) tick();
    test_reset();
    test_masked_write();
    test_hold();
    test_out_of_range();
    test_clr();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
